// File: rtl/ppu_nmi_gen.sv
// Vblank flag and NMI generator: dot/scanline timing, PPUCTRL/PPUSTATUS bus snooping
// and a one-clock NMI pulse on every rising edge of the NMI level.
module ppu_nmi_gen #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRE_LINE        = 261
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        dot_tick,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  ppu_status,
    output logic        nmi_out,
    output logic        nmi_pulse,
    output logic [8:0]  dot,
    output logic [8:0]  scanline,
    output logic        frame_odd
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
    localparam logic [8:0] PRE_LN    = 9'(PRE_LINE);

    localparam logic [1:0] PH_RENDER    = 2'd0;
    localparam logic [1:0] PH_POST      = 2'd1;
    localparam logic [1:0] PH_VBLANK    = 2'd2;
    localparam logic [1:0] PH_PRERENDER = 2'd3;

    logic [8:0] dot_reg, dot_next;
    logic [8:0] scanline_reg, scanline_next;
    logic       frame_odd_reg, frame_odd_next;
    logic [1:0] phase_reg, phase_next, phase_calc;
    logic       vblank_flag_reg, vblank_flag_next;
    logic       nmi_enable_reg, nmi_enable_next;
    logic [7:0] ppu_status_reg;
    logic       nmi_out_reg;
    logic       nmi_pulse_reg;
    logic       nmi_hist_reg;
    logic       nmi_level_next;

    logic       reg_hit;
    logic [2:0] reg_idx;
    logic       ctrl_write;
    logic       status_read;
    logic       vblank_set;
    logic       vblank_clr;

    // Only the decode bits of the address matter; the rest are mirror bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[12:3];

    assign reg_hit     = (cpu_addr[15:13] == 3'b001);
    assign reg_idx     = cpu_addr[2:0];
    assign ctrl_write  = reg_hit && cpu_write_en && (reg_idx == 3'd0);
    // A read colliding with a write strobe is dropped so the write wins.
    assign status_read = reg_hit && cpu_read_en && !cpu_write_en && (reg_idx == 3'd2);

    always_comb begin
        dot_next       = dot_reg;
        scanline_next  = scanline_reg;
        frame_odd_next = frame_odd_reg;
        if (dot_tick) begin
            if (dot_reg == DOT_LAST) begin
                dot_next = '0;
                if (scanline_reg == LINE_LAST) begin
                    scanline_next  = '0;
                    frame_odd_next = ~frame_odd_reg;
                end else begin
                    scanline_next = scanline_reg + 9'd1;
                end
            end else begin
                dot_next = dot_reg + 9'd1;
            end
        end
    end

    // Phase is derived from where the counters land after this edge.
    always_comb begin
        phase_calc = PH_PRERENDER;
        if (scanline_next < VBL_LINE) begin
            phase_calc = PH_RENDER;
        end else if (scanline_next == VBL_LINE && dot_next == 9'd0) begin
            phase_calc = PH_POST;
        end else if (scanline_next < PRE_LN || (scanline_next == PRE_LN && dot_next == 9'd0)) begin
            phase_calc = PH_VBLANK;
        end
        phase_next = dot_tick ? phase_calc : phase_reg;
    end

    assign vblank_set = dot_tick && (phase_reg == PH_POST)   && (phase_next == PH_VBLANK);
    assign vblank_clr = dot_tick && (phase_reg == PH_VBLANK) && (phase_next == PH_PRERENDER);

    always_comb begin
        nmi_enable_next = ctrl_write ? cpu_data_in[7] : nmi_enable_reg;
        vblank_flag_next = vblank_flag_reg;
        if (vblank_set) begin
            vblank_flag_next = 1'b1;
        end
        if (vblank_clr) begin
            vblank_flag_next = 1'b0;
        end
        // A read on the setting edge wins, suppressing that frame's vblank.
        if (status_read) begin
            vblank_flag_next = 1'b0;
        end
        nmi_level_next = vblank_flag_next & nmi_enable_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dot_reg         <= '0;
            scanline_reg    <= '0;
            frame_odd_reg   <= 1'b0;
            phase_reg       <= PH_RENDER;
            vblank_flag_reg <= 1'b0;
            nmi_enable_reg  <= 1'b0;
            ppu_status_reg  <= '0;
            nmi_out_reg     <= 1'b0;
            nmi_pulse_reg   <= 1'b0;
            nmi_hist_reg    <= 1'b0;
        end else if (!halt) begin
            dot_reg         <= dot_next;
            scanline_reg    <= scanline_next;
            frame_odd_reg   <= frame_odd_next;
            phase_reg       <= phase_next;
            vblank_flag_reg <= vblank_flag_next;
            nmi_enable_reg  <= nmi_enable_next;
            ppu_status_reg  <= {vblank_flag_next, 7'b0};
            nmi_out_reg     <= nmi_level_next;
            nmi_pulse_reg   <= nmi_level_next & ~nmi_hist_reg;
            nmi_hist_reg    <= nmi_level_next;
        end
    end

    assign ppu_status = ppu_status_reg;
    assign nmi_out    = nmi_out_reg;
    // The held pulse is masked while frozen so nothing fires during a halt.
    assign nmi_pulse  = nmi_pulse_reg & ~halt;
    assign dot        = dot_reg;
    assign scanline   = scanline_reg;
    assign frame_odd  = frame_odd_reg;

endmodule

// File: tb/tb_ppu_nmi_gen.sv
// Directed bench for ppu_nmi_gen using a shrunken frame (20 dots x 12 lines,
// vblank on line 9, pre-render on line 11) so several frames fit in a short run.
module tb_ppu_nmi_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        dot_tick;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [7:0]  ppu_status;
    logic        nmi_out;
    logic        nmi_pulse;
    logic [8:0]  dot;
    logic [8:0]  scanline;
    logic        frame_odd;

    int checks    = 0;
    int errors    = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    ppu_nmi_gen #(
        .DOTS_PER_LINE  (20),
        .LINES_PER_FRAME(12),
        .VBLANK_LINE    (9),
        .PRE_LINE       (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .dot_tick    (dot_tick),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_write_en(cpu_write_en),
        .cpu_read_en (cpu_read_en),
        .ppu_status  (ppu_status),
        .nmi_out     (nmi_out),
        .nmi_pulse   (nmi_pulse),
        .dot         (dot),
        .scanline    (scanline),
        .frame_odd   (frame_odd)
    );

    task automatic step(input logic tick, input logic we, input logic re,
                        input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        dot_tick     = tick;
        cpu_write_en = we;
        cpu_read_en  = re;
        cpu_addr     = addr;
        cpu_data_in  = data;
        @(posedge clk);
        #1;
        if (nmi_pulse === 1'b1) pulse_cnt++;
        dot_tick     = 1'b0;
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        step(1'b0, 1'b1, 1'b0, addr, data);
        $display("txn write addr=%04h data=%02h -> status=%02h nmi_out=%0b nmi_pulse=%0b",
                 addr, data, ppu_status, nmi_out, nmi_pulse);
    endtask

    task automatic rd(input logic [15:0] addr);
        step(1'b0, 1'b0, 1'b1, addr, 8'h00);
        $display("txn read  addr=%04h -> status=%02h nmi_out=%0b nmi_pulse=%0b",
                 addr, ppu_status, nmi_out, nmi_pulse);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        halt         = 1'b1;
        dot_tick     = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_data_in  = 8'h00;
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b0;

        // Reset beats halt, ticks and bus strobes
        step(1'b1, 1'b1, 1'b0, 16'h2000, 8'h80);
        chk("rst_dot", dot, 0);
        chk("rst_line", scanline, 0);
        chk("rst_odd", frame_odd, 0);
        chk("rst_status", ppu_status, 8'h00);
        chk("rst_nmi", nmi_out, 0);
        chk("rst_pulse", nmi_pulse, 0);
        halt = 1'b0;
        step(1'b1, 1'b1, 1'b0, 16'h2000, 8'h80);
        chk("rst2_dot", dot, 0);
        chk("rst2_nmi", nmi_out, 0);
        rst = 1'b1;

        // First tick after release
        run(1);
        chk("first_dot", dot, 1);
        chk("first_line", scanline, 0);

        // Frame 0: enable NMI, reach vblank
        wr(16'h2000, 8'h80);
        pulse_cnt = 0;
        run(179);
        chk("f0_pre_dot", dot, 0);
        chk("f0_pre_line", scanline, 9);
        chk("f0_pre_status", ppu_status, 8'h00);
        chk("f0_pre_nmi", nmi_out, 0);
        run(1);
        chk("f0_set_dot", dot, 1);
        chk("f0_set_line", scanline, 9);
        chk("f0_set_status", ppu_status, 8'h80);
        chk("f0_set_nmi", nmi_out, 1);
        chk("f0_set_pulse", nmi_pulse, 1);

        // Re-arm toggles during vblank
        wr(16'h2000, 8'h00);
        chk("f0_dis_nmi", nmi_out, 0);
        chk("f0_dis_status", ppu_status, 8'h80);
        wr(16'h2002, 8'h00);
        chk("f0_wr2_status", ppu_status, 8'h80);
        wr(16'hA000, 8'h80);
        chk("f0_nohit_nmi", nmi_out, 0);
        wr(16'h2000, 8'h80);
        chk("f0_rearm1_nmi", nmi_out, 1);
        chk("f0_rearm1_pulse", nmi_pulse, 1);
        wr(16'h2000, 8'h00);
        wr(16'h2000, 8'h80);
        chk("f0_rearm2_pulse", nmi_pulse, 1);
        chk("f0_pulse_cnt", pulse_cnt, 3);

        // Both strobes on $2002: read dropped, flag survives
        step(1'b0, 1'b1, 1'b1, 16'h2002, 8'h00);
        chk("f0_both_status", ppu_status, 8'h80);
        chk("f0_both_nmi", nmi_out, 1);

        rd(16'h2002);
        chk("f0_rd_status", ppu_status, 8'h00);
        chk("f0_rd_nmi", nmi_out, 0);
        chk("f0_rd_pulse", nmi_pulse, 0);

        run(59);
        chk("f0_wrap_dot", dot, 0);
        chk("f0_wrap_line", scanline, 0);
        chk("f0_wrap_odd", frame_odd, 1);
        chk("f0_wrap_cnt", pulse_cnt, 3);

        // Frame 1: status read on the setting edge
        run(180);
        step(1'b1, 1'b0, 1'b1, 16'h2002, 8'h00);
        chk("f1_race_dot", dot, 1);
        chk("f1_race_line", scanline, 9);
        chk("f1_race_status", ppu_status, 8'h00);
        chk("f1_race_nmi", nmi_out, 0);
        chk("f1_race_pulse", nmi_pulse, 0);
        wr(16'h2000, 8'h00);
        wr(16'h2000, 8'h80);
        chk("f1_toggle_nmi", nmi_out, 0);
        run(59);
        chk("f1_wrap_line", scanline, 0);
        chk("f1_wrap_odd", frame_odd, 0);
        chk("f1_wrap_cnt", pulse_cnt, 3);

        // Frame 2: halt freezes everything, including bus writes
        run(180);
        halt = 1'b1;
        run(3);
        chk("f2_halt_dot", dot, 0);
        chk("f2_halt_line", scanline, 9);
        chk("f2_halt_status", ppu_status, 8'h00);
        wr(16'h2000, 8'h00);
        halt = 1'b0;
        run(1);
        chk("f2_set_status", ppu_status, 8'h80);
        chk("f2_set_nmi", nmi_out, 1);
        chk("f2_set_pulse", nmi_pulse, 1);
        halt = 1'b1;
        run(1);
        chk("f2_halt_pulse", nmi_pulse, 0);
        chk("f2_halt_dot2", dot, 1);
        halt = 1'b0;
        run(39);
        chk("f2_pre_line", scanline, 11);
        chk("f2_pre_status", ppu_status, 8'h80);
        run(1);
        chk("f2_clr_dot", dot, 1);
        chk("f2_clr_status", ppu_status, 8'h00);
        chk("f2_clr_nmi", nmi_out, 0);
        run(219);
        chk("f3_line", scanline, 10);
        chk("f3_nmi", nmi_out, 1);
        chk("f3_odd", frame_odd, 1);
        chk("f3_cnt", pulse_cnt, 5);

        // Reset mid-vblank, then enable through a mirror address
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("mrst_line", scanline, 0);
        chk("mrst_dot", dot, 0);
        chk("mrst_odd", frame_odd, 0);
        chk("mrst_status", ppu_status, 8'h00);
        chk("mrst_nmi", nmi_out, 0);
        chk("mrst_pulse", nmi_pulse, 0);
        chk("mrst_cnt", pulse_cnt, 5);
        rst = 1'b1;
        wr(16'h3FF8, 8'h80);
        run(1);
        chk("mir_first_dot", dot, 1);
        run(180);
        chk("mir_status", ppu_status, 8'h80);
        chk("mir_nmi", nmi_out, 1);
        chk("mir_pulse", nmi_pulse, 1);
        chk("mir_cnt", pulse_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
